// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg
//   Shared constants for the microwave cook timer: FSM state encodings,
//   BCD digit limits and the well-known time values.
package cook_timer_pkg;

    // FSM state encodings (2 bits)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Value a digit wraps to when it borrows from the digit above
    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] DIG_MAX   = 4'd9;

    localparam logic [15:0] TIME_ZERO = 16'h0000;
    localparam logic [15:0] TIME_TEST = 16'h8888;

endpackage

// File: rtl/cook_timer_tick_gen.sv
// tick_gen
//   One-second prescaler. Counts 0..TICK_DIV-1 while en is high, holds while
//   en is low, and returns to 0 on clr (clr wins over en).
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   en     in   count enable
//   clr    in   synchronous clear of the prescaler
//   tick   out  combinational: prescaler at TICK_DIV-1 and en high
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/cook_timer.sv
// cook_timer
//   Loads a 4-digit BCD MM:SS value and counts it down once per second while
//   cook is high. done is raised when the count reaches 00:00.
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   load       in   capture time_load this cycle (highest priority)
//   time_load  in   BCD {min_t,min_u,sec_t,sec_u}
//   cook       in   count enable
//   time_left  out  current BCD count (registered)
//   done       out  count reached 0000 while cooking (registered level)
//   running    out  high in RUN state (registered)
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] time_load,
    input  logic        cook,
    output logic [15:0] time_left,
    output logic        done,
    output logic        running
);

    // Per-digit borrow, LSB digit first. A digit only changes when every
    // lower digit was 0; non-BCD nibbles just decrement.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        logic        borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] != 4'd0) begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end else begin
                    r[i*4 +: 4] = (i == 1) ? SEC_T_MAX : DIG_MAX;
                end
            end
        end
        return r;
    endfunction

    logic [1:0]  state, state_nxt;
    logic [15:0] tl_nxt, dec_val;
    logic        done_nxt;
    logic        tick;

    // Prescaler only advances in RUN with cook high, so pausing keeps the
    // partial second; load restarts it.
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    ((state == ST_RUN) && cook),
        .clr   (load),
        .tick  (tick)
    );

    assign dec_val = bcd_dec(time_left);

    always_comb begin
        state_nxt = state;
        tl_nxt    = time_left;
        done_nxt  = done;
        if (load) begin
            tl_nxt   = time_load;
            done_nxt = 1'b0;
            if (cook)
                state_nxt = (time_load == TIME_ZERO) ? ST_DONE : ST_RUN;
            else
                state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cook) begin
                        if (time_left == TIME_ZERO) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!cook) begin
                        state_nxt = ST_PAUSE;
                    end else if (tick) begin
                        tl_nxt = dec_val;
                        if (dec_val == TIME_ZERO) begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cook) state_nxt = ST_RUN;
                end
                default: begin
                    // DONE: sticky until the next load, cook ignored
                    done_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            time_left <= TIME_ZERO;
            done      <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            time_left <= tl_nxt;
            done      <= done_nxt;
            running   <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer
//   Directed scoreboard bench for cook_timer with TICK_DIV=4. Each stimulus
//   step queues the values expected after the next rising edge; a monitor
//   pops and compares on the falling edge. A random phase checks that done
//   implies 0000 and that the count stays valid BCD.
module tb_cook_timer;
    import cook_timer_pkg::*;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] time_load = 16'h0;
    logic        cook = 1'b0;
    logic [15:0] time_left;
    logic        done;
    logic        running;

    always #5 clk = ~clk;

    cook_timer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .time_load (time_load),
        .cook      (cook),
        .time_left (time_left),
        .done      (done),
        .running   (running)
    );

    typedef struct {
        bit          chk;
        logic [15:0] tl;
        logic        dn;
        logic        rn;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vecs = 0;
    int   errs = 0;
    bit   prop_on = 1'b0;

    function automatic bit bcd_ok(input logic [15:0] t);
        return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    task automatic cmp(input string nm, input logic [15:0] etl,
                       input logic ed, input logic er);
        vecs++;
        if (time_left !== etl || done !== ed || running !== er) begin
            errs++;
            $display("FAIL %s: got tl=%h done=%b run=%b, expected tl=%h done=%b run=%b",
                     nm, time_left, done, running, etl, ed, er);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            if (mon_e.chk) cmp(mon_e.name, mon_e.tl, mon_e.dn, mon_e.rn);
        end
        if (prop_on) begin
            vecs++;
            if (done && time_left !== TIME_ZERO) begin
                errs++;
                $display("FAIL done_implies_zero: got tl=%h with done=1, expected 0000", time_left);
            end
            vecs++;
            if (!bcd_ok(time_left)) begin
                errs++;
                $display("FAIL bcd_valid: got tl=%h, expected valid BCD", time_left);
            end
        end
    end

    // Drive one cycle of inputs, queue what must be seen after the edge.
    task automatic step(input logic ld, input logic [15:0] tl, input logic ck,
                        input bit chk, input logic [15:0] etl,
                        input logic ed, input logic er, input string nm);
        exp_t e;
        load      = ld;
        time_load = tl;
        cook      = ck;
        e.chk  = chk;
        e.tl   = etl;
        e.dn   = ed;
        e.rn   = er;
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic ck, input logic [15:0] etl,
                        input logic ed, input logic er, input string nm);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, ck, 1'b1, etl, ed, er, nm);
    endtask

    initial begin
        logic [15:0] rt;
        logic        rl, rc;

        // reset state
        #2;
        cmp("reset_state", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // 0003 counts down to 0000 at cycles 4/8/12
        step(1'b1, 16'h0003, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, "load_0003");
        for (int k = 1; k <= 13; k++)
            step(1'b0, 16'h0, 1'b1, 1'b1,
                 (k >= 12) ? 16'h0000 : 16'(3 - k / 4),
                 (k >= 12), (k < 12), "count_0003");

        // minute borrows
        step(1'b1, 16'h0100, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, "load_0100");
        hold(3, 1'b1, 16'h0100, 1'b0, 1'b1, "wait_0100");
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0059, 1'b0, 1'b1, "dec_0100");
        step(1'b1, 16'h1000, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b1, "load_1000");
        hold(3, 1'b1, 16'h1000, 1'b0, 1'b1, "wait_1000");
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0959, 1'b0, 1'b1, "dec_1000");

        // pause keeps the partial second
        step(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, "load_0010");
        hold(3, 1'b1, 16'h0010, 1'b0, 1'b1, "run_0010");
        hold(3, 1'b1, 16'h0009, 1'b0, 1'b1, "run_0009");
        hold(10, 1'b0, 16'h0009, 1'b0, 1'b0, "pause_0009");
        hold(2, 1'b1, 16'h0009, 1'b0, 1'b1, "resume_0009");
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b1, "resume_dec");

        // display-test value loads raw and idles
        step(1'b1, TIME_TEST, 1'b0, 1'b1, 16'h8888, 1'b0, 1'b0, "load_8888");
        hold(3, 1'b0, 16'h8888, 1'b0, 1'b0, "idle_8888");
        hold(4, 1'b1, 16'h8888, 1'b0, 1'b1, "run_8888");
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h8887, 1'b0, 1'b1, "dec_8888");

        // load on a tick edge wins
        hold(3, 1'b1, 16'h8887, 1'b0, 1'b1, "pre_tick");
        step(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b1, "load_on_tick");
        hold(3, 1'b1, 16'h0005, 1'b0, 1'b1, "restart_0005");
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, "dec_0005");

        // load 0000 while cooking
        step(1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, "load_0000");
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "done_0000");
        hold(3, 1'b0, 16'h0000, 1'b1, 1'b0, "done_cook_ign");

        // async reset mid-RUN
        step(1'b1, 16'h0042, 1'b1, 1'b1, 16'h0042, 1'b0, 1'b1, "load_0042");
        hold(2, 1'b1, 16'h0042, 1'b0, 1'b1, "run_0042");
        #2;
        reset = 1'b0;
        #1;
        cmp("async_reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        // zero count with cook high goes to DONE without a load
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "post_reset");
        hold(2, 1'b1, 16'h0000, 1'b1, 1'b0, "post_reset_done");

        // random stream with property checks
        prop_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rl = ($urandom_range(7) == 0);
            rc = ($urandom_range(3) != 0);
            if ($urandom_range(5) == 0)
                rt = 16'h0000;
            else
                rt = {4'($urandom_range(9)), 4'($urandom_range(9)),
                      4'($urandom_range(5)), 4'($urandom_range(9))};
            step(rl, rt, rc, 1'b0, 16'h0, 1'b0, 1'b0, "random");
        end
        prop_on = 1'b0;

        vecs++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
